// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - master-side sequencer for the serial shared bus
module bus_master_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_slave,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic              m_request,
    output logic              m_address_valid,
    output logic              m_address,
    output logic              m_data,
    output logic              m_valid,
    output logic              m_write_en,
    input  logic              m_ready,
    input  logic              m_available,
    input  logic              m_data_in,
    input  logic              m_valid_in
);
    localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_SLV, S_WAIT_RDY, S_ADDR, S_WDATA, S_RDATA, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        slave_q, slave_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic [DATA_W-1:0] rshift_q, rshift_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              on_bus;

    assign on_bus = (state_q == S_SLV) || (state_q == S_WAIT_RDY) || (state_q == S_ADDR)
                 || (state_q == S_WDATA) || (state_q == S_RDATA);

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        slave_d   = slave_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rshift_d  = rshift_q;
        rdata_d   = rdata_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;
        // Shifters reload from the latched command outside their phase, so a retry re-sends everything
        addr_sh_d = (state_q == S_ADDR)  ? {addr_sh_q[ADDR_W-2:0], 1'b0} : addr_q;
        data_sh_d = (state_q == S_WDATA) ? {data_sh_q[DATA_W-2:0], 1'b0} : wdata_q;

        if (on_bus && !m_available) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                state_d = S_REQ;
            end else begin
                state_d = S_ERR;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    if (start) begin
                        if (cmd_slave != 2'd3) begin
                            write_d = cmd_write;
                            slave_d = cmd_slave;
                            addr_d  = cmd_addr;
                            wdata_d = cmd_wdata;
                            retry_d = '0;
                            state_d = S_REQ;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    if (m_available) begin
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                        state_d   = S_SLV;
                    end
                end
                S_SLV: begin
                    if (bit_cnt_q == CW'(1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_WAIT_RDY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (m_ready) begin
                        to_cnt_d = '0;
                        state_d  = S_ADDR;
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (bit_cnt_q == CW'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                        state_d   = write_q ? S_WDATA : S_RDATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (bit_cnt_q == CW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (m_valid_in) begin
                        rshift_d = {rshift_q[DATA_W-2:0], m_data_in};
                        to_cnt_d = '0;
                        if (bit_cnt_q == CW'(DATA_W - 1)) begin
                            rdata_d   = {rshift_q[DATA_W-2:0], m_data_in};
                            bit_cnt_d = '0;
                            state_d   = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            slave_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            rshift_q  <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            slave_q   <= slave_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            rshift_q  <= rshift_d;
            rdata_q   <= rdata_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
        end
    end

    // Every output below is a decode of registered state only
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE) || (state_q == S_ERR);
    assign error           = (state_q == S_ERR);
    assign rdata           = rdata_q;
    assign m_request       = (state_q == S_REQ) || on_bus;
    assign m_address_valid = (state_q == S_REQ);
    assign m_valid         = (state_q == S_SLV) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign m_write_en      = ((state_q == S_ADDR) && write_q) || (state_q == S_WDATA);
    assign m_data          = (state_q == S_WDATA) && data_sh_q[DATA_W-1];

    always_comb begin
        m_address = 1'b0;
        if (state_q == S_SLV) begin
            m_address = bit_cnt_q[0] ? slave_q[0] : slave_q[1];
        end else if (state_q == S_ADDR) begin
            m_address = addr_sh_q[ADDR_W-1];
        end
    end
endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb/tb_bus_master_ctrl.sv - directed self-checking bench for bus_master_ctrl
module tb_bus_master_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, cmd_write;
    logic [1:0]  cmd_slave;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        busy, done, error;
    logic [7:0]  rdata;
    logic        m_request, m_address_valid, m_address, m_data, m_valid, m_write_en;
    logic        m_ready, m_available, m_data_in, m_valid_in;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] addr_seq = '0;
    logic [63:0] data_seq = '0;
    int          nbits    = 0;
    int          we_cnt   = 0;

    always #5 clk = ~clk;

    bus_master_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .cmd_write(cmd_write),
        .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .error(error), .rdata(rdata),
        .m_request(m_request), .m_address_valid(m_address_valid),
        .m_address(m_address), .m_data(m_data), .m_valid(m_valid),
        .m_write_en(m_write_en), .m_ready(m_ready), .m_available(m_available),
        .m_data_in(m_data_in), .m_valid_in(m_valid_in)
    );

    // Serial capture; a REQ cycle (m_address_valid) discards a partial transfer
    always @(negedge clk) begin
        if (m_address_valid) begin
            addr_seq <= '0;
            data_seq <= '0;
            nbits    <= 0;
        end else if (m_valid) begin
            addr_seq <= {addr_seq[62:0], m_address};
            data_seq <= {data_seq[62:0], m_data};
            nbits    <= nbits + 1;
        end
        if (m_write_en) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle during which start is presented
    task automatic cmd_start(input logic w, input logic [1:0] s, input logic [11:0] a,
                             input logic [7:0] d);
        step();
        start     = 1'b1;
        cmd_write = w;
        cmd_slave = s;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        logic [9:0] pv;
        logic [7:0] rd_word;
        int         k;
        int         we0;
        int         req_low;
        int         done_cnt;

        reset = 1'b1; start = 1'b0; cmd_write = 1'b0; cmd_slave = '0;
        cmd_addr = '0; cmd_wdata = '0; m_ready = 1'b1; m_available = 1'b1;
        m_data_in = 1'b0; m_valid_in = 1'b0;
        repeat (3) step();
        check("rst_outputs", 32'({busy, done, error, m_request, m_address_valid, m_address,
                                  m_data, m_valid, m_write_en, rdata}), 32'd0);
        reset = 1'b0;
        step();

        // Write, no stalls
        cmd_start(1'b1, 2'd1, 12'hA5C, 8'h3C);
        for (int c = 2; c <= 27; c++) begin
            step();
            if (c == 2) begin
                start = 1'b0;
                check("t1_req", 32'({m_request, m_address_valid}), 32'd3);
            end
            if (c == 25) check("t1_c25", 32'({m_request, done}), 32'd2);
            if (c == 26) check("t1_c26_done", 32'({done, error, m_request}), 32'd4);
            if (c == 27) check("t1_c27_idle", 32'({busy, done}), 32'd0);
        end
        check("t1_nbits", 32'(nbits), 32'd22);
        check("t1_addr_seq", 32'(addr_seq[21:0]), 32'({2'b01, 12'hA5C, 8'h00}));
        check("t1_data_seq", 32'(data_seq[21:0]), 32'({14'd0, 8'h3C}));

        // Read with gapped m_valid_in
        pv      = 10'b1011011111;
        rd_word = 8'h96;
        k       = 7;
        we0     = we_cnt;
        cmd_start(1'b0, 2'd2, 12'h001, 8'h00);
        for (int c = 2; c <= 29; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c == 17) check("t2_last_addr", 32'(m_valid), 32'd1);
            if (c == 18) check("t2_rdata_entry", 32'({m_valid, busy}), 32'd1);
            if (c == 27) check("t2_c27", 32'({done, rdata}), 32'd0);
            if (c == 28) check("t2_done", 32'({done, error, rdata}), 32'({2'b10, 8'h96}));
            if (c == 29) check("t2_idle", 32'(busy), 32'd0);
            m_valid_in = 1'b0;
            m_data_in  = 1'b0;
            if (c >= 18 && c <= 27 && pv[9-(c-18)]) begin
                m_valid_in = 1'b1;
                m_data_in  = rd_word[k];
                k--;
            end
        end
        check("t2_no_write_en", 32'(we_cnt - we0), 32'd0);
        check("t2_addr_seq", 32'({nbits[7:0], addr_seq[13:0]}), 32'({8'd14, 2'b10, 12'h001}));

        // Read timeout: nothing ever returned
        cmd_start(1'b0, 2'd0, 12'h123, 8'h00);
        for (int c = 2; c <= 35; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c == 18) check("t3_rdata_entry", 32'({m_valid, busy}), 32'd1);
            if (c == 33) check("t3_c33", 32'(done), 32'd0);
            if (c == 34) check("t3_timeout", 32'({done, error, rdata}), 32'({2'b11, 8'h96}));
            if (c == 35) check("t3_idle", 32'(busy), 32'd0);
        end

        // Write with grant lost for 3 cycles at address bit 5
        req_low = 0;
        cmd_start(1'b1, 2'd2, 12'h3F0, 8'hA5);
        for (int c = 2; c <= 40; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c <= 38 && !m_request) req_low++;
            if (c == 12) check("t4_in_addr", 32'({m_valid, m_write_en}), 32'd3);
            if (c == 13) check("t4_back_req", 32'({m_request, m_address_valid}), 32'd3);
            if (c == 15) check("t4_still_req", 32'(m_address_valid), 32'd1);
            if (c == 16) check("t4_resume_slv", 32'({m_valid, m_address_valid}), 32'd2);
            if (c == 38) check("t4_c38", 32'(done), 32'd0);
            if (c == 39) check("t4_done", 32'({done, error}), 32'd2);
            if (c == 40) check("t4_idle", 32'(busy), 32'd0);
            m_available = !(c >= 12 && c <= 14);
        end
        check("t4_req_held", 32'(req_low), 32'd0);
        check("t4_nbits", 32'(nbits), 32'd22);
        check("t4_addr_seq", 32'(addr_seq[21:0]), 32'({2'b10, 12'h3F0, 8'h00}));
        check("t4_data_seq", 32'(data_seq[21:0]), 32'({14'd0, 8'hA5}));

        // Four grant losses in one command
        cmd_start(1'b0, 2'd1, 12'h055, 8'h00);
        for (int c = 2; c <= 11; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c == 4) check("t5_retry_req", 32'(m_address_valid), 32'd1);
            if (c == 9) check("t5_c9", 32'({done, m_request}), 32'd1);
            if (c == 10) check("t5_err", 32'({done, error, m_request}), 32'd6);
            if (c == 11) check("t5_idle", 32'(busy), 32'd0);
            m_available = !(c == 3 || c == 5 || c == 7 || c == 9);
        end

        // Illegal slave select
        cmd_start(1'b1, 2'd3, 12'h000, 8'h00);
        step();
        start = 1'b0;
        check("t5b_err", 32'({done, error, busy, m_request}), 32'd14);
        step();
        check("t5b_idle", 32'({done, busy, m_request}), 32'd0);

        // Start pulses while busy must not disturb the running write
        cmd_start(1'b1, 2'd1, 12'h0F0, 8'h55);
        for (int c = 2; c <= 28; c++) begin
            step();
            start = (c == 4 || c == 10 || c == 20);
            if (c == 4) begin
                cmd_write = 1'b0; cmd_slave = 2'd2; cmd_addr = 12'hFFF; cmd_wdata = 8'h00;
            end
            if (c == 26) check("t6_done", 32'({done, error}), 32'd2);
            if (c == 27) check("t6_idle", 32'(busy), 32'd0);
            if (c == 28) check("t6_not_queued", 32'({busy, m_request}), 32'd0);
        end
        check("t6_addr_seq", 32'(addr_seq[21:0]), 32'({2'b01, 12'h0F0, 8'h00}));
        check("t6_data_seq", 32'(data_seq[21:0]), 32'({14'd0, 8'h55}));

        // Reset in the middle of WDATA
        done_cnt = 0;
        cmd_start(1'b1, 2'd0, 12'h800, 8'hFF);
        for (int c = 2; c <= 30; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c >= 21 && done) done_cnt++;
            if (c == 20) begin
                check("t7_in_wdata", 32'({m_data, m_write_en, m_valid}), 32'd7);
                reset = 1'b1;
            end
            if (c == 21) check("t7_rst_outputs", 32'({busy, done, error, m_request,
                               m_address_valid, m_address, m_data, m_valid, m_write_en,
                               rdata}), 32'd0);
            if (c == 23) reset = 1'b0;
        end
        check("t7_no_done", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_master_ctrl.md
Name: bus_master_ctrl

Overview:
- Master-side sequencer for the serial shared bus. Runs one transaction per command from the local master logic onto one bus master port (m1 or m2), through the two-master/three-slave arbiter.
- Requests the bus, then shifts the 2-bit slave select and the serial memory address. For a write it then shifts out the write data; for a read it collects the read data.
- Handles loss of grant (split/master switch) with bounded retries and slave/response timeouts.

Parameters:
- ADDR_W, 12, memory address bits shifted after slave select, MSB first
- DATA_W, 8, data word width, MSB first on the serial lines
- TIMEOUT, 16, consecutive idle cycles allowed in WAIT_RDY or RDATA before error (>=2)
- MAX_RETRY, 3, grant-loss restarts allowed per command before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_slave  in  2  slave select, 0..2; 3 is illegal
- cmd_addr  in  ADDR_W  memory address
- cmd_wdata  in  DATA_W  write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  high with done when the command failed
- rdata  out  DATA_W  last successfully read word
- m_request  out  1  bus request to arbiter
- m_address_valid  out  1  address phase start to arbiter
- m_address  out  1  serial slave-select/address bit
- m_data  out  1  serial write data bit
- m_valid  out  1  qualifies m_address/m_data
- m_write_en  out  1  write qualifier
- m_ready  in  1  connected slave ready, via arbiter
- m_available  in  1  arbiter is not serving the other master
- m_data_in  in  1  serial read data
- m_valid_in  in  1  qualifies m_data_in

Behaviour:
- Output timing: all bus outputs and status outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Reset: state IDLE; all outputs 0; rdata 0; counters 0. Reset mid-transaction aborts immediately with no done pulse.
- IDLE:
  - If start=1 and cmd_slave!=3: latch the command, clear retry_cnt, go to REQ.
  - If start=1 and cmd_slave=3: go to ERR.
- REQ:
  - Drives m_request=1, m_address_valid=1.
  - When m_available=1 is sampled, go to SLV.
- SLV (2 cycles):
  - Drives m_address = slave[1], then slave[0], with m_valid=1.
  - Then go to WAIT_RDY.
- WAIT_RDY:
  - Drives m_valid=0.
  - m_ready=1 -> ADDR.
  - TIMEOUT cycles elapsed -> ERR.
- ADDR (ADDR_W cycles):
  - Drives m_address = addr bits MSB first, m_valid=1, m_write_en=cmd_write.
  - Then go to WDATA (write) or RDATA (read).
- WDATA (DATA_W cycles):
  - Drives m_data MSB first, m_valid=1, m_write_en=1.
  - Then go to DONE.
- RDATA:
  - Drives m_valid=0, m_write_en=0.
  - Each cycle with m_valid_in=1 shifts m_data_in into a shift register and resets the timeout count.
  - After DATA_W bits: load rdata, go to DONE.
  - TIMEOUT consecutive cycles without m_valid_in -> ERR; rdata unchanged.
- m_request: held 1 from REQ through the last bus cycle; 0 in DONE, ERR and IDLE.
- Grant loss:
  - Checked in SLV, WAIT_RDY, ADDR, WDATA and RDATA. If m_available=0 is sampled:
    - retry_cnt < MAX_RETRY: increment retry_cnt, clear bit and timeout counters, go to REQ; the transaction restarts from SLV.
    - otherwise: go to ERR.
  - Grant loss takes priority over m_ready, m_valid_in and bit completion in the same cycle.
- DONE: done=1, error=0 for one cycle, then IDLE.
- ERR: done=1, error=1 for one cycle, then IDLE.
- start while busy=1 is ignored, not queued.
- Latency (write, no stalls): done is high 6+ADDR_W+DATA_W cycles after the edge that samples start (26 with defaults).

Test Plan:
- Write cmd_slave=1, cmd_addr=0xA5C, cmd_wdata=0x3C; m_available=1; m_ready=1 from first WAIT_RDY cycle -> m_address shows 0,1 then 101001011100; m_data shows 00111100; done (error=0) at cycle 26; m_request drops at cycle 26.
- Read cmd_slave=2, cmd_addr=0x001; slave returns 0x96 with m_valid_in gapped (pattern 1,0,1,1,0,1,1,1,1,1) -> rdata=0x96 at the done cycle, error=0, m_write_en=0 throughout.
- Read with m_valid_in never asserted -> done=1, error=1 exactly TIMEOUT=16 cycles after RDATA entry; rdata keeps its prior value.
- Write with m_available dropped for 3 cycles at ADDR bit 5 -> FSM returns to REQ with m_request held; resumes at SLV after m_available=1; full address and data re-sent; done, error=0.
- Four grant losses in one command -> done with error=1 on the fourth loss; start with cmd_slave=3 -> error pulse one cycle after start, no m_request.
- Reset asserted during WDATA, plus start pulses while busy -> all outputs 0 next cycle, no done pulse; start pulses during busy leave the current command's fields unchanged.
